// File: rtl/comple2_pkg.sv
// Shared constants for the chunked two's-complement unit: operand modes,
// FSM encoding and a most-negative-value helper.
package comple2_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_NEG  = 2'b01;
    localparam logic [1:0] MODE_ABS  = 2'b10;
    localparam logic [1:0] MODE_RSV  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Widths up to 64 bits; callers truncate to their own width.
    function automatic logic [63:0] min_neg(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/comple2_chunk.sv
// CHUNK-bit conditional complement-and-increment slice; a ripple of per-bit
// cells so the carry chain is only CHUNK long.
module comple2_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic             cin,
    input  logic             cmp,
    output logic [CHUNK-1:0] r,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic x;
        assign x      = a[i] ^ cmp;
        assign r[i]   = x ^ c[i];
        assign c[i+1] = x & c[i];
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/comple2_secuencial.sv
// Multi-cycle negate / pass / abs unit: one CHUNK-bit slice per clock, LSB
// first, with valid/ready on both sides.
//
// state   | meaning
// IDLE    | waiting for an operand
// BUSY    | NCHUNK cycles of chunk processing
// DONE    | result held until the consumer takes it
module comple2_secuencial
    import comple2_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("comple2_secuencial: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_t           state;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] r_ext;
    logic [CHUNK-1:0] r;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cout;
    logic             cmp;
    logic             cmp_in;
    logic             ovf_q;
    logic             accept;

    assign in_ready = rst_n & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    always_comb begin
        cmp_in = 1'b0;
        case (in_mode)
            MODE_NEG: cmp_in = 1'b1;
            MODE_ABS: cmp_in = in_data[WIDTH-1];
            default:  cmp_in = 1'b0;
        endcase
    end

    comple2_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (opnd[CHUNK-1:0]),
        .cin  (carry),
        .cmp  (cmp),
        .r    (r),
        .cout (cout)
    );

    // New slice enters at the MSB side; after NCHUNK shifts the word is aligned.
    assign r_ext    = WIDTH'(r) << (WIDTH - CHUNK);
    assign res_next = (res >> CHUNK) | r_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            opnd      <= '0;
            res       <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            cmp       <= 1'b0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            case (state)
                ST_BUSY: begin
                    res   <= res_next;
                    opnd  <= opnd >> CHUNK;
                    carry <= cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(NCHUNK - 1)) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        out_data  <= res_next;
                        out_ovf   <= ovf_q;
                        out_zero  <= (res_next == '0);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_IDLE: ;
                default: state <= ST_IDLE;
            endcase

            // Accept overrides the DONE->IDLE move so a handoff goes straight to BUSY.
            if (accept) begin
                opnd  <= in_data;
                cmp   <= cmp_in;
                carry <= cmp_in;
                cnt   <= '0;
                ovf_q <= cmp_in & (in_data == WIDTH'(min_neg(WIDTH)));
                state <= ST_BUSY;
            end
        end
    end

endmodule

// File: doc/comple2_secuencial.md
# comple2_secuencial

Multi-cycle, parametrised two's-complement unit. It negates, passes through, or takes the absolute value of a WIDTH-bit operand by processing CHUNK bits per clock, LSB first, with a registered carry between chunks. It trades latency for a short carry chain and sits between operand registers and the ALU datapath. Both sides use a valid/ready handshake.

## Interface
- WIDTH, 16: operand width in bits. Must be ≥ 2.
- CHUNK, 4: bits processed per cycle. WIDTH % CHUNK must equal 0; elaboration fails otherwise.
- NCHUNK, WIDTH/CHUNK: derived localparam, not overridable.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  operand accepted when high together with in_valid.
- in_data  in  WIDTH  operand.
- in_mode  in  2  00 pass, 01 negate, 10 abs, 11 reserved (treated as pass).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_data  out  WIDTH  result.
- out_ovf  out  1  complement of the most-negative value requested.
- out_zero  out  1  out_data == 0.

## Operation
- FSM states:
  - IDLE: waiting for an operand.
  - BUSY: NCHUNK cycles of chunk processing.
  - DONE: result held until the consumer takes it.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Forced to 0 while rst_n is low.
- Accept (in_valid & in_ready):
  - Latch in_data into the operand shift register.
  - Latch cmp: negate → 1; abs → in_data[WIDTH-1]; pass/reserved → 0.
  - Set carry = cmp, chunk counter = 0, state → BUSY.
- Each BUSY cycle:
  - Slice result {cout, r} = (a_chunk ^ {CHUNK{cmp}}) + carry.
  - r is shifted into the result register MSB side.
  - carry ← cout. Operand shifts right by CHUNK. Counter increments.
- After the chunk with counter == NCHUNK-1: state → DONE, out_valid = 1.
- Final carry out of the top chunk is discarded. Arithmetic is modulo 2^WIDTH.
- out_ovf = cmp & (operand == {1'b1, {WIDTH-1{1'b0}}}). Result is then equal to the operand. Flag is computed at accept and registered.
- out_zero is derived from the final result and registered with out_valid.
- DONE:
  - out_data, out_ovf and out_zero are held stable while out_valid & !out_ready.
  - On out_ready: out_valid drops, unless a new operand is accepted in the same cycle, in which case state → BUSY directly.
- in_mode and in_data are ignored outside the accept cycle.

## Timing
- Reset values:
  - state = IDLE.
  - out_valid, out_data, out_ovf, out_zero = 0.
  - in_ready = 0 while rst_n is low; 1 from the first cycle after release.
- Latency: accept on edge k gives out_valid high after edge k+NCHUNK.
- Throughput:
  - Back-to-back (DONE handoff): one result per NCHUNK+1 cycles.
  - Via IDLE: NCHUNK+2 cycles.
- CHUNK == WIDTH: NCHUNK = 1, one-cycle BUSY.
- Reset asserted mid-BUSY or in DONE: immediate abort to IDLE; all outputs cleared; the partial result is lost.
- Simultaneous out_ready and in_valid in DONE: both transfers occur on the same edge.

## Structure
- Package comple2_pkg holds:
  - mode localparams MODE_PASS, MODE_NEG, MODE_ABS, MODE_RSV;
  - FSM state encoding ST_IDLE, ST_BUSY, ST_DONE;
  - function min_neg(width) returning the most-negative pattern.
- Sub-module comple2_chunk: parametrised CHUNK-bit conditional-complement/increment slice.
  - Inputs: a[CHUNK], cin, cmp. Outputs: r[CHUNK], cout.
  - Built as a generate chain of per-bit complement cells.
  - Instantiated once; reused every BUSY cycle.
- Top contains the FSM, chunk counter ($clog2(NCHUNK) bits, min 1), shift registers, carry flop and flag logic.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless stated.
- Negate 0x0001 → out_data 0xFFFF, ovf 0, zero 0; out_valid exactly 4 cycles after the accept edge.
- Abs 0xFF9C → 0x0064. Abs 0x0064 → 0x0064. Pass 0x1234 → 0x1234. Mode 11 with 0xABCD → 0xABCD.
- Negate 0x8000 → 0x8000, ovf 1. Negate 0x0000 → 0x0000, zero 1, ovf 0. Abs 0x8000 → 0x8000, ovf 1.
- Backpressure:
  - Hold out_ready low for 10 cycles in DONE → out_data stable, in_ready 0.
  - Then assert out_ready with in_valid high → same-edge handoff; next result 5 cycles later.
- Reset:
  - Pulse rst_n low during the second BUSY chunk → outputs clear asynchronously, state IDLE.
  - Next operation, negate 0x00FF, yields 0xFF01.
- Parameter sweep (WIDTH,CHUNK) = (8,1), (8,8), (32,4), (16,16):
  - 1000 random operands and modes checked against a behavioural model.
  - Latency = WIDTH/CHUNK in every case.
